// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: bus/register widths, load encodings
// and the load formatting function used on the memory return path.
package writeback_stage_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       bus_type;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LW  = 3'b010,
    LOAD_LBU = 3'b100,
    LOAD_LHU = 3'b101
  } load_op_type;

  typedef struct packed {
    logic    valid;
    bus_type data;
  } load_result_t;

  typedef struct packed {
    reg_addr_t rd;
    bus_type   data;
  } wb_entry_t;

  // Unsupported encodings come back invalid with zero data.
  function automatic load_result_t format_load(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo,
                                               input bus_type    rdata);
    load_result_t r;
    logic [7:0]   b;
    logic [15:0]  h;
    b       = rdata[{addr_lo, 3'b000} +: 8];
    h       = rdata[{addr_lo[1], 4'b0000} +: 16];
    r.valid = 1'b1;
    r.data  = '0;
    case (funct3)
      LOAD_LB:  r.data = {{24{b[7]}}, b};
      LOAD_LBU: r.data = {24'b0, b};
      LOAD_LH:  r.data = {{16{h[15]}}, h};
      LOAD_LHU: r.data = {16'b0, h};
      LOAD_LW:  r.data = rdata;
      default:  r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering ALU results while the register-file write
// port is busy with loads. Storage is not reset; only pointers and count are.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates loads (never stalled) against buffered/bypassed
// ALU results for the single register-file write port.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  bus_type               alu_data,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [2:0]            mem_funct3,
  input  logic [1:0]            mem_addr_lo,
  input  bus_type               mem_rdata,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output bus_type               rf_input_data,
  output logic                  rf_enable,
  output logic                  busy
);

  wb_entry_t    head;
  wb_entry_t    alu_entry;
  load_result_t ld;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_empty;
  logic         fifo_full;
  logic         alu_fire;
  logic         sel_write;
  reg_addr_t    sel_rd;
  bus_type      sel_data;

  // Ready depends only on the registered fill level, never on this cycle's pop.
  assign alu_ready = ~rst & ~fifo_full;
  assign alu_fire  = alu_valid & alu_ready;
  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign ld        = format_load(mem_funct3, mem_addr_lo, mem_rdata);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(wb_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (alu_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    sel_write = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (!rst) begin
      if (mem_valid) begin
        sel_write = ld.valid & (mem_rd != '0);
        sel_rd    = mem_rd;
        sel_data  = ld.data;
        fifo_push = alu_fire;
      end else if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        sel_write = (head.rd != '0);
        sel_rd    = head.rd;
        sel_data  = head.data;
        fifo_push = alu_fire;
      end else if (alu_fire) begin
        sel_write = (alu_rd != '0);
        sel_rd    = alu_rd;
        sel_data  = alu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_enable     <= 1'b0;
      rf_write_addr <= '0;
      rf_input_data <= '0;
    end else begin
      rf_enable     <= sel_write;
      rf_write_addr <= sel_rd;
      rf_input_data <= sel_data;
    end
  end

  assign busy = ~fifo_empty | rf_enable;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: load-format vector table, ALU scoreboard and
// directed sequences for bypass, collision, backpressure, x0 and reset.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rdata;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_input_data;
  logic        rf_enable;
  logic        busy;

  writeback_stage #(.FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_rd        (mem_rd),
    .mem_funct3    (mem_funct3),
    .mem_addr_lo   (mem_addr_lo),
    .mem_rdata     (mem_rdata),
    .rf_write_addr (rf_write_addr),
    .rf_input_data (rf_input_data),
    .rf_enable     (rf_enable),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic        en;
    logic [31:0] data;
  } vec_t;

  int checks = 0;
  int errors = 0;
  wr_t alu_q[$];
  int  alu_acc = 0;
  logic        mon_on = 1'b0;
  logic        drv_en = 1'b0;
  logic [31:0] drv_data = '0;
  logic        exp_v = 1'b0;
  logic        exp_en = 1'b0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Capture what the DUT samples at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_v = 1'b0;
      alu_q.delete();
    end else begin
      exp_v    = mem_valid;
      exp_en   = drv_en;
      exp_rd   = mem_rd;
      exp_data = drv_data;
      if (alu_valid && alu_ready) begin
        alu_acc++;
        if (alu_rd != 5'd0) alu_q.push_back('{alu_rd, alu_data});
      end
    end
  end

  // Loads must land one cycle later; everything else must be the oldest ALU result.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_v) begin
        chk("sb_load_en", rf_enable, exp_en);
        chk("sb_load_data", rf_input_data, exp_data);
        if (exp_en) chk("sb_load_addr", rf_write_addr, exp_rd);
      end else if (rf_enable) begin
        if (alu_q.size() == 0) begin
          chk("sb_unexpected_write", rf_enable, 1'b0);
        end else begin
          wr_t w;
          w = alu_q.pop_front();
          chk("sb_alu_addr", rf_write_addr, w.rd);
          chk("sb_alu_data", rf_input_data, w.data);
        end
      end
    end
  end

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    drv_en    = 1'b0;
    drv_data  = '0;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                            input logic [31:0] rdata, input logic en, input logic [31:0] data);
    mem_valid   = 1'b1;
    mem_funct3  = f3;
    mem_addr_lo = off;
    mem_rd      = rd;
    mem_rdata   = rdata;
    drv_en      = en;
    drv_data    = data;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
  endtask

  vec_t vecs[12];
  logic bp_ready_exp[4];

  initial begin
    vecs[0]  = '{3'b000, 2'd3, 32'h80FF_7F01, 1'b1, 32'hFFFF_FF80};
    vecs[1]  = '{3'b100, 2'd3, 32'h80FF_7F01, 1'b1, 32'h0000_0080};
    vecs[2]  = '{3'b001, 2'd2, 32'h80FF_7F01, 1'b1, 32'hFFFF_80FF};
    vecs[3]  = '{3'b101, 2'd0, 32'h80FF_7F01, 1'b1, 32'h0000_7F01};
    vecs[4]  = '{3'b010, 2'd1, 32'h80FF_7F01, 1'b1, 32'h80FF_7F01};
    vecs[5]  = '{3'b000, 2'd1, 32'h80FF_7F01, 1'b1, 32'h0000_007F};
    vecs[6]  = '{3'b001, 2'd3, 32'h80FF_7F01, 1'b1, 32'hFFFF_80FF};
    vecs[7]  = '{3'b101, 2'd1, 32'h80FF_7F01, 1'b1, 32'h0000_7F01};
    vecs[8]  = '{3'b011, 2'd0, 32'h80FF_7F01, 1'b0, 32'h0000_0000};
    vecs[9]  = '{3'b111, 2'd2, 32'h80FF_7F01, 1'b0, 32'h0000_0000};
    vecs[10] = '{3'b100, 2'd2, 32'h80FF_7F01, 1'b1, 32'h0000_00FF};
    vecs[11] = '{3'b000, 2'd2, 32'h80FF_7F01, 1'b1, 32'hFFFF_FFFF};
    bp_ready_exp = '{1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    alu_rd = '0; alu_data = '0; mem_rd = '0; mem_funct3 = '0;
    mem_addr_lo = '0; mem_rdata = '0;
    idle_inputs();
    drive_alu(5'd9, 32'hBAD0_0001);
    repeat (3) @(negedge clk);
    #1 chk("ready_in_reset", alu_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("reset_rf_enable", rf_enable, 1'b0);
    chk("reset_addr", rf_write_addr, 5'd0);
    chk("reset_data", rf_input_data, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", alu_ready, 1'b1);
    mon_on = 1'b1;

    // Bypass
    @(negedge clk);
    drive_alu(5'd5, 32'h1234_5678);
    @(negedge clk);
    idle_inputs();
    chk("bypass_en", rf_enable, 1'b1);
    chk("bypass_addr", rf_write_addr, 5'd5);
    chk("bypass_data", rf_input_data, 32'h1234_5678);

    // Collision: load wins, ALU result follows one cycle later
    @(negedge clk);
    drive_load(3'b010, 2'd0, 5'd3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    drive_alu(5'd4, 32'h0000_0011);
    @(negedge clk);
    idle_inputs();
    chk("coll_first_addr", rf_write_addr, 5'd3);
    chk("coll_first_data", rf_input_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("coll_second_en", rf_enable, 1'b1);
    chk("coll_second_addr", rf_write_addr, 5'd4);
    chk("coll_second_data", rf_input_data, 32'h0000_0011);
    @(negedge clk);
    chk("coll_quiet", rf_enable, 1'b0);

    // Load formatting table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive_load(vecs[i].f3, vecs[i].off, 5'(i + 1), vecs[i].rdata, vecs[i].en, vecs[i].data);
      @(negedge clk);
      idle_inputs();
      chk($sformatf("fmt%0d_en", i), rf_enable, vecs[i].en);
      chk($sformatf("fmt%0d_data", i), rf_input_data, vecs[i].data);
    end

    // Backpressure under continuous loads
    begin
      int base;
      int waited;
      base = alu_acc;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        drive_load(3'b010, 2'd0, 5'(20 + i), 32'hC000_0000 + i, 1'b1, 32'hC000_0000 + i);
        drive_alu(5'(10 + alu_acc - base), 32'hA0 + (alu_acc - base));
        #1 chk($sformatf("bp_ready%0d", i), alu_ready, bp_ready_exp[i]);
      end
      @(negedge clk);
      idle_inputs();
      chk("bp_accepts", alu_acc - base, 2);
      waited = 0;
      while (busy && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      chk("bp_drain_timeout", waited < 10, 1'b1);
      chk("bp_queue_left", alu_q.size(), 0);
    end

    // x0 write then illegal load
    @(negedge clk);
    drive_alu(5'd0, 32'h0000_0055);
    @(negedge clk);
    idle_inputs();
    drive_load(3'b011, 2'd0, 5'd9, 32'h0000_1234, 1'b0, 32'h0);
    chk("x0_en", rf_enable, 1'b0);
    @(negedge clk);
    idle_inputs();
    chk("illegal_en", rf_enable, 1'b0);
    chk("illegal_data", rf_input_data, 32'h0);
    @(negedge clk);
    chk("x0_busy", busy, 1'b0);

    // Reset while the FIFO is full
    @(negedge clk);
    drive_load(3'b010, 2'd0, 5'd12, 32'h0000_0C0C, 1'b1, 32'h0000_0C0C);
    drive_alu(5'd13, 32'h0000_0077);
    @(negedge clk);
    drive_load(3'b010, 2'd0, 5'd14, 32'h0000_0E0E, 1'b1, 32'h0000_0E0E);
    drive_alu(5'd15, 32'h0000_0088);
    @(negedge clk);
    chk("rst_full_ready", alu_ready, 1'b0);
    rst = 1'b1;
    drive_load(3'b010, 2'd0, 5'd16, 32'h0000_1616, 1'b1, 32'h0000_1616);
    drive_alu(5'd17, 32'h0000_0099);
    #1 chk("rst_ready_low", alu_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rst_after_en", rf_enable, 1'b0);
    chk("rst_after_ready", alu_ready, 1'b1);
    chk("rst_after_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_quiet%0d", i), rf_enable, 1'b0);
    end
    chk("final_queue_empty", alu_q.size(), 0);

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
